// File: rtl/mem_access_pkg.sv
// Shared size codes, FSM state type and byte-lane mask helper for the memory access unit.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Byte lanes a store of the given size touches; unsigned codes never store.
    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return off[1] ? 4'b1100 : 4'b0011;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend from a DRAM word and store merge into an old word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] base_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  mask;

    assign byte_sel = load_word_i[8*off_i +: 8];
    assign half_sel = off_i[1] ? load_word_i[31:16] : load_word_i[15:0];
    assign mask     = byte_mask(funct3_i, off_i);

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            F3_W:    load_data_o = load_word_i;
            default: load_data_o = '0;
        endcase
    end

    // Store data is replicated across lanes so each lane only needs its own mask bit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_src;
            assign lane_src = (funct3_i == F3_W) ? wdata_i[8*gi +: 8] :
                              (funct3_i == F3_H) ? wdata_i[8*(gi%2) +: 8] :
                                                   wdata_i[7:0];
            assign store_word_o[8*gi +: 8] = mask[gi] ? lane_src : base_word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit over a word-addressed DRAM with combinational read port.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_BITS-1:0] dram_a,
    output logic                 dram_we,
    output logic [31:0]          dram_d,
    input  logic [31:0]          dram_spo
);

    state_e                 state_q, state_d;
    logic                   we_q;
    logic [2:0]             funct3_q;
    logic [ADDR_BITS+1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic [31:0]            old_word_q;
    logic [31:0]            resp_rdata_q;
    logic                   resp_err_q;
    logic                   resp_valid_q;
    logic                   req_err;
    logic                   accept;
    logic [31:0]            load_data;
    logic [31:0]            store_word;

    always_comb begin
        req_err = 1'b0;
        case (req_funct3)
            F3_B:    req_err = 1'b0;
            F3_BU:   req_err = req_we;
            F3_H:    req_err = req_addr[0];
            F3_HU:   req_err = req_we | req_addr[0];
            F3_W:    req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if ((req_addr >> (ADDR_BITS + 2)) != 32'd0)
            req_err = 1'b1;
    end

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        dram_we = 1'b0;
        dram_a  = '0;
        case (state_q)
            IDLE:  if (accept) state_d = req_err ? RESP : READ;
            READ:  begin
                dram_a  = addr_q[ADDR_BITS+1:2];
                state_d = we_q ? WRITE : RESP;
            end
            WRITE: begin
                dram_a  = addr_q[ADDR_BITS+1:2];
                dram_we = 1'b1;
                state_d = RESP;
            end
            RESP:  if (resp_valid_q && resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            dram_we = 1'b0;
            dram_a  = '0;
        end
    end

    // resp_valid rises one cycle into RESP and drops on the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            old_word_q   <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    we_q         <= req_we;
                    funct3_q     <= req_funct3;
                    addr_q       <= req_addr[ADDR_BITS+1:0];
                    wdata_q      <= req_wdata;
                    resp_rdata_q <= '0;
                    resp_err_q   <= req_err;
                end
                READ: begin
                    old_word_q <= dram_spo;
                    if (!we_q) resp_rdata_q <= load_data;
                end
                RESP: begin
                    if (!resp_valid_q)
                        resp_valid_q <= 1'b1;
                    else if (resp_ready)
                        resp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mem_lane_align u_align (
        .funct3_i     (funct3_q),
        .off_i        (addr_q[1:0]),
        .load_word_i  (dram_spo),
        .base_word_i  (old_word_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    assign dram_d     = store_word;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, meaning the width of the DRAM word index.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  in  1  request offered.
REQ-005 SHALL have port req_ready  out  1  unit can accept a request.
REQ-006 SHALL have port req_we  in  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port req_addr  in  32  byte address.
REQ-009 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  out  1  response available.
REQ-011 SHALL have port resp_ready  in  1  consumer takes response.
REQ-012 SHALL have port resp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  misaligned, illegal or out-of-range request.
REQ-014 SHALL have port dram_a  out  ADDR_BITS  word index to DRAM.
REQ-015 SHALL have port dram_we  out  1  DRAM write enable.
REQ-016 SHALL have port dram_d  out  32  DRAM write word.
REQ-017 SHALL have port dram_spo  in  32  DRAM combinational read word.

Function
REQ-018 SHALL implement the FSM states IDLE, READ, WRITE and RESP; req_ready SHALL equal (state==IDLE).
REQ-019 SHALL accept a request on a cycle with req_valid&&req_ready, registering we, funct3, addr and wdata.
REQ-020 SHALL flag an error for: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; stores with funct3 BU/HU; addr[31:ADDR_BITS+2]!=0.
REQ-021 SHALL take an errored request IDLE->RESP with resp_err=1 and no DRAM write.
REQ-022 SHALL take a load IDLE->READ->RESP; in READ, sample dram_spo and register the extracted result.
REQ-023 SHALL take a store IDLE->READ->WRITE->RESP; READ captures the old word, WRITE asserts dram_we for exactly one cycle with the merged word.
REQ-024 SHALL drive dram_a = addr[ADDR_BITS+1:2] of the registered request in READ and WRITE, and 0 otherwise.
REQ-025 SHALL use little-endian lanes: byte lane k is bits [8k+7:8k]; half lane is addr[1].
REQ-026 SHALL extract loads as: B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-027 SHALL merge stores as: SB replaces the lane with wdata[7:0], SH replaces the half with wdata[15:0], SW replaces the whole word; other bytes SHALL be preserved.
REQ-028 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then go to IDLE.
REQ-029 SHALL NOT accept a new request in the RESP exit cycle; req_ready rises the cycle after.
REQ-030 SHALL give a load accepted at edge T resp_valid=1 after edge T+2, and a store after edge T+3, when resp_ready is held high.
REQ-031 SHALL gate dram_we as (state==WRITE)&&!rst.

Reset
REQ-032 SHALL, on rst at a clock edge, set state IDLE, resp_valid 0, resp_rdata 0, resp_err 0 and all captured request registers 0.
REQ-033 SHALL abort any in-flight operation on rst: a store in WRITE performs no write, and no response is produced.
REQ-034 SHALL drive dram_we=0 and dram_a=0 whenever rst is high.

Structure
REQ-035 SHALL place the funct3 size constants and the FSM state enum in shared package mem_access_pkg.
REQ-036 SHALL implement lane extract/sign-extend and store merge in one combinational sub-module mem_lane_align.

Verification
REQ-037 SHALL cover: DRAM word 0 = 0x8899AABB, LB addr 0x1 -> resp_rdata 0xFFFFFFAA, resp_err=0, resp_valid at T+2.
REQ-038 SHALL cover: same word, LHU addr 0x2 -> 0x00008899; LH addr 0x2 -> 0xFFFF8899.
REQ-039 SHALL cover: word 1 = 0x11223344, SB addr 0x6 wdata 0xFFFFFF55 -> exactly one dram_we pulse, word 1 becomes 0x11553344, response at T+3.
REQ-040 SHALL cover: LW addr 0x2 and SH addr 0x3 -> resp_err=1, resp_rdata=0, no dram_we, response after one cycle.
REQ-041 SHALL cover: resp_ready held low for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-042 SHALL cover: rst asserted in WRITE of an SW 0xDEADBEEF -> target word unchanged, resp_valid=0, req_ready=1 the next cycle.
